a10_xcvr_multi_pll_calibrator: RTL and testbench
================================================

A10_XCVR_MULTI_PLL_CALIBRATOR -- requirements
Module: a10_xcvr_multi_pll_calibrator

Interface
REQ-001 SHALL have parameter PLL_COUNT, default 2, number of serviced PLLs (1..8).
REQ-002 SHALL have parameter PLL_TYPE, default "fPLL", one of "fPLL" | "CMUPLL" | "ATXPLL"; it sets CAL_MASK: "ATXPLL" 32'h01, "fPLL" 32'h02, "CMUPLL" 32'h20.
REQ-003 SHALL have parameter RST_DELAY, default 200, pll_powerdown pulse length in clk cycles (>=1).
REQ-004 SHALL have parameter TIMEOUT, default 65535, wait-state limit in clk cycles (>=1).
REQ-005 SHALL have the ports below, clock and reset first; one clock; reset is asynchronous and active-high.
- clk  in  1  reconfiguration/system clock
- reset  in  1  asynchronous active-high reset
- recal_req  in  PLL_COUNT  per-PLL single-cycle recalibration request
- reconfig_select  out  PLL_COUNT  one-hot target of the current Avalon-MM access
- reconfig_address  out  10  Avalon-MM address
- reconfig_write  out  1  Avalon-MM write
- reconfig_read  out  1  Avalon-MM read
- reconfig_writedata  out  32  Avalon-MM write data
- reconfig_readdata  in  32*PLL_COUNT  per-PLL read data, PLL i at [32i+31:32i]
- reconfig_waitrequest  in  PLL_COUNT  per-PLL waitrequest
- pll_powerdown  out  PLL_COUNT  per-PLL powerdown
- pll_cal_busy  in  PLL_COUNT  per-PLL calibration busy
- pll_locked  in  PLL_COUNT  per-PLL lock
- ready  out  PLL_COUNT  PLL i calibrated, reset and locked
- error  out  PLL_COUNT  PLL i failed by timeout
- busy  out  1  sequencer not IDLE

Function
REQ-006 SHALL keep a pending vector; it SHALL be all ones on reset release; recal_req[i]=1 SHALL set pending[i] and clear ready[i] and error[i] on the same edge.
REQ-007 In IDLE with any pending bit set, the sequencer SHALL select the lowest-index pending PLL i, clear pending[i], and enter REQ_BUS on the next cycle.
REQ-008 Each Avalon-MM access SHALL be held stable (address, data, read/write, select) while reconfig_waitrequest[i]=1 and SHALL complete on the first cycle with reconfig_waitrequest[i]=0; read data SHALL be sampled on that cycle.
REQ-009 States and transitions:
- REQ_BUS: write 0x000 <- 32'h02 -> WAIT_BUS.
- WAIT_BUS: read 0x280; repeat while readdata bit 2 = 1; bit 2 = 0 -> RD_CAL.
- RD_CAL: read 0x100, capture value V -> WR_CAL.
- WR_CAL: write 0x100 <- V | CAL_MASK -> REL_BUS.
- REL_BUS: write 0x000 <- 32'h01 -> WAIT_CAL.
- WAIT_CAL: wait for pll_cal_busy[i]=1, then for 0 -> PWRDN.
- PWRDN: pll_powerdown[i]=1 for exactly RST_DELAY cycles -> WAIT_LOCK.
- WAIT_LOCK: pll_locked[i]=1 -> ready[i]=1 -> IDLE.
REQ-010 WAIT_BUS, WAIT_CAL and WAIT_LOCK SHALL share one counter, cleared on state entry; reaching TIMEOUT cycles SHALL set error[i]=1, keep ready[i]=0, release the bus (write 0x000 <- 32'h01 if the timeout occurs in WAIT_BUS), and return to IDLE.
REQ-011 recal_req[i] during service of PLL i SHALL set pending[i] again; PLL i SHALL be re-serviced after the current sequence, and the current sequence SHALL NOT set ready[i].
REQ-012 Simultaneous requests SHALL be serviced in ascending index order, one PLL at a time.
REQ-013 Outside an access, reconfig_read, reconfig_write and reconfig_select SHALL be 0; at most one of reconfig_read/reconfig_write SHALL be 1.
REQ-014 ready[i] SHALL clear when pll_locked[i] falls while PLL i is not being serviced; no automatic recalibration SHALL follow.

Reset
REQ-015 On reset, outputs SHALL be: reconfig_* = 0, pll_powerdown = 0, ready = 0, error = 0, busy = 0; state = IDLE; counters = 0.
REQ-016 Reset asserted mid-sequence SHALL abort immediately with no bus release; after deassertion, all PLLs SHALL be re-serviced from REQ_BUS.

Verification
REQ-017 PLL_COUNT=2, fPLL, RST_DELAY=4, WAIT_BUS readdata 0x4 then 0x0, RD_CAL readdata 0x10 -> WR_CAL writedata 0x12; PLL0 then PLL1 complete; ready=2'b11.
REQ-018 waitrequest held high 5 cycles on the REQ_BUS write -> outputs stable for 6 cycles; exactly one write observed.
REQ-019 TIMEOUT=16, pll_cal_busy[0] never rises -> error[0]=1 after 16 cycles in WAIT_CAL; PLL1 still completes with ready=2'b10.
REQ-020 recal_req=2'b11 in one cycle while idle -> PLL0 then PLL1 serviced; pll_powerdown pulses of exactly 4 cycles, never overlapping.
REQ-021 recal_req[1] during PLL1 PWRDN -> PLL1 sequence repeats once; ready[1] rises only after the second lock.
REQ-022 reset pulse during WR_CAL of PLL0 -> all outputs return to reset values immediately; after release, REQ_BUS write to PLL0 restarts.

Source files
------------

// File: rtl/a10_xcvr_multi_pll_calibrator.sv
// a10_xcvr_multi_pll_calibrator
// Sequences recalibration of up to eight transceiver PLLs over a shared
// Avalon-MM reconfiguration bus. Each PLL is serviced in turn:
// 1. request the bus,
// 2. set its calibration bit,
// 3. hand the bus back,
// 4. wait for calibration to finish,
// 5. pulse powerdown,
// 6. wait for lock.
module a10_xcvr_multi_pll_calibrator #(
    parameter int    PLL_COUNT = 2,
    parameter string PLL_TYPE  = "fPLL",
    parameter int    RST_DELAY = 200,
    parameter int    TIMEOUT   = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PLL_COUNT-1:0]     recal_req,
    output logic [PLL_COUNT-1:0]     reconfig_select,
    output logic [9:0]               reconfig_address,
    output logic                     reconfig_write,
    output logic                     reconfig_read,
    output logic [31:0]              reconfig_writedata,
    input  logic [32*PLL_COUNT-1:0]  reconfig_readdata,
    input  logic [PLL_COUNT-1:0]     reconfig_waitrequest,
    output logic [PLL_COUNT-1:0]     pll_powerdown,
    input  logic [PLL_COUNT-1:0]     pll_cal_busy,
    input  logic [PLL_COUNT-1:0]     pll_locked,
    output logic [PLL_COUNT-1:0]     ready,
    output logic [PLL_COUNT-1:0]     error,
    output logic                     busy
);

    localparam int IDX_W = (PLL_COUNT > 1) ? $clog2(PLL_COUNT) : 1;

    // Calibration-enable bit differs per PLL flavour; fPLL is the fallback.
    localparam logic [31:0] CAL_MASK = (PLL_TYPE == "ATXPLL") ? 32'h0000_0001 :
                                       (PLL_TYPE == "CMUPLL") ? 32'h0000_0020 :
                                                                32'h0000_0002;

    localparam logic [9:0]  ADDR_ARB  = 10'h000;
    localparam logic [9:0]  ADDR_STAT = 10'h280;
    localparam logic [9:0]  ADDR_CAL  = 10'h100;
    localparam logic [31:0] ARB_REQ   = 32'h0000_0002;
    localparam logic [31:0] ARB_REL   = 32'h0000_0001;
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);
    localparam logic [31:0] PD_LAST   = 32'(RST_DELAY - 1);

    typedef enum logic [3:0] {
        IDLE,
        REQ_BUS,
        WAIT_BUS,
        RD_CAL,
        WR_CAL,
        REL_BUS,
        WAIT_CAL,
        PWRDN,
        WAIT_LOCK,
        TO_REL
    } state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       cur, cur_nxt;
    logic [31:0]            cnt, cnt_nxt;
    logic                   cal_seen, cal_seen_nxt;
    logic [PLL_COUNT-1:0]   pending, pending_nxt;
    logic [PLL_COUNT-1:0]   ready_nxt, error_nxt;
    logic [31:0]            cal_val;
    logic                   cal_capture;

    logic [PLL_COUNT-1:0]   cur_oh;
    logic [31:0]            cur_rdata;
    logic                   cur_wait;
    logic                   cur_cal_busy;
    logic                   cur_locked;
    logic [IDX_W-1:0]       sel_idx;
    logic                   timeout;

    // Per-PLL views of the currently serviced PLL and lowest pending index.
    always_comb begin
        cur_oh    = '0;
        cur_rdata = '0;
        sel_idx   = '0;
        for (int i = 0; i < PLL_COUNT; i++) begin
            cur_oh[i] = (cur == IDX_W'(i));
            if (cur == IDX_W'(i)) begin
                cur_rdata = reconfig_readdata[i*32 +: 32];
            end
        end
        for (int i = PLL_COUNT - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        cur_wait     = |(reconfig_waitrequest & cur_oh);
        cur_cal_busy = |(pll_cal_busy & cur_oh);
        cur_locked   = |(pll_locked & cur_oh);
        timeout      = (cnt == TO_LAST);
    end

    // Next-state, status updates and bus/powerdown outputs.
    always_comb begin
        state_nxt          = state;
        cur_nxt            = cur;
        cnt_nxt            = cnt + 32'd1;
        cal_seen_nxt       = cal_seen;
        pending_nxt        = pending;
        ready_nxt          = ready;
        error_nxt          = error;
        cal_capture        = 1'b0;
        reconfig_select    = '0;
        reconfig_address   = '0;
        reconfig_write     = 1'b0;
        reconfig_read      = 1'b0;
        reconfig_writedata = '0;
        pll_powerdown      = '0;

        case (state)
            IDLE: begin
                if (|pending) begin
                    cur_nxt              = sel_idx;
                    pending_nxt[sel_idx] = 1'b0;
                    state_nxt            = REQ_BUS;
                end
            end
            REQ_BUS: begin
                reconfig_select    = cur_oh;
                reconfig_address   = ADDR_ARB;
                reconfig_write     = 1'b1;
                reconfig_writedata = ARB_REQ;
                if (!cur_wait) begin
                    state_nxt = WAIT_BUS;
                end
            end
            WAIT_BUS: begin
                // Poll the arbitration status until the bus is ours.
                reconfig_select  = cur_oh;
                reconfig_address = ADDR_STAT;
                reconfig_read    = 1'b1;
                if (!cur_wait && !cur_rdata[2]) begin
                    state_nxt = RD_CAL;
                end else if (timeout) begin
                    error_nxt = error | cur_oh;
                    state_nxt = TO_REL;
                end
            end
            RD_CAL: begin
                reconfig_select  = cur_oh;
                reconfig_address = ADDR_CAL;
                reconfig_read    = 1'b1;
                if (!cur_wait) begin
                    cal_capture = 1'b1;
                    state_nxt   = WR_CAL;
                end
            end
            WR_CAL: begin
                reconfig_select    = cur_oh;
                reconfig_address   = ADDR_CAL;
                reconfig_write     = 1'b1;
                reconfig_writedata = cal_val | CAL_MASK;
                if (!cur_wait) begin
                    state_nxt = REL_BUS;
                end
            end
            REL_BUS: begin
                reconfig_select    = cur_oh;
                reconfig_address   = ADDR_ARB;
                reconfig_write     = 1'b1;
                reconfig_writedata = ARB_REL;
                if (!cur_wait) begin
                    cal_seen_nxt = 1'b0;
                    state_nxt    = WAIT_CAL;
                end
            end
            WAIT_CAL: begin
                // Calibration must be seen to start before its end counts.
                if (cal_seen && !cur_cal_busy) begin
                    state_nxt = PWRDN;
                end else begin
                    if (cur_cal_busy) begin
                        cal_seen_nxt = 1'b1;
                    end
                    if (timeout) begin
                        error_nxt = error | cur_oh;
                        state_nxt = IDLE;
                    end
                end
            end
            PWRDN: begin
                pll_powerdown = cur_oh;
                if (cnt == PD_LAST) begin
                    state_nxt = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (cur_locked) begin
                    // A re-request during service voids this pass.
                    if (!(|(pending & cur_oh))) begin
                        ready_nxt = ready | cur_oh;
                    end
                    state_nxt = IDLE;
                end else if (timeout) begin
                    error_nxt = error | cur_oh;
                    state_nxt = IDLE;
                end
            end
            TO_REL: begin
                reconfig_select    = cur_oh;
                reconfig_address   = ADDR_ARB;
                reconfig_write     = 1'b1;
                reconfig_writedata = ARB_REL;
                if (!cur_wait) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Shared wait counter restarts on every state change.
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end

        // Requests override everything for their PLL on the same edge.
        pending_nxt = pending_nxt | recal_req;
        error_nxt   = error_nxt & ~recal_req;
        ready_nxt   = ready_nxt & ~recal_req;

        // Loss of lock drops ready for PLLs not currently in service.
        ready_nxt = ready_nxt & (pll_locked | ((state != IDLE) ? cur_oh : '0));

        busy = (state != IDLE);
    end

    // Control and status registers; reset aborts any sequence in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cur      <= '0;
            cnt      <= '0;
            cal_seen <= 1'b0;
            pending  <= '1;
            ready    <= '0;
            error    <= '0;
        end else begin
            state    <= state_nxt;
            cur      <= cur_nxt;
            cnt      <= cnt_nxt;
            cal_seen <= cal_seen_nxt;
            pending  <= pending_nxt;
            ready    <= ready_nxt;
            error    <= error_nxt;
        end
    end

    // Calibration register value read back in RD_CAL, only used in WR_CAL.
    always_ff @(posedge clk) begin
        if (cal_capture) begin
            cal_val <= cur_rdata;
        end
    end

endmodule

// File: tb/tb_a10_xcvr_multi_pll_calibrator.sv
// Directed bench for a10_xcvr_multi_pll_calibrator (2 fPLLs, RST_DELAY=4,
// TIMEOUT=16). Inputs change and outputs are checked on the falling edge.
module tb_a10_xcvr_multi_pll_calibrator;

    logic        clk;
    logic        reset;
    logic [1:0]  recal_req;
    logic [1:0]  reconfig_select;
    logic [9:0]  reconfig_address;
    logic        reconfig_write;
    logic        reconfig_read;
    logic [31:0] reconfig_writedata;
    logic [63:0] reconfig_readdata;
    logic [1:0]  reconfig_waitrequest;
    logic [1:0]  pll_powerdown;
    logic [1:0]  pll_cal_busy;
    logic [1:0]  pll_locked;
    logic [1:0]  ready;
    logic [1:0]  error;
    logic        busy;

    int checks;
    int errors;
    int wr_done;
    int wr_base;

    a10_xcvr_multi_pll_calibrator #(
        .PLL_COUNT (2),
        .PLL_TYPE  ("fPLL"),
        .RST_DELAY (4),
        .TIMEOUT   (16)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .recal_req            (recal_req),
        .reconfig_select      (reconfig_select),
        .reconfig_address     (reconfig_address),
        .reconfig_write       (reconfig_write),
        .reconfig_read        (reconfig_read),
        .reconfig_writedata   (reconfig_writedata),
        .reconfig_readdata    (reconfig_readdata),
        .reconfig_waitrequest (reconfig_waitrequest),
        .pll_powerdown        (pll_powerdown),
        .pll_cal_busy         (pll_cal_busy),
        .pll_locked           (pll_locked),
        .ready                (ready),
        .error                (error),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check {select, address, write, read, writedata, powerdown, busy}.
    task automatic look(input string tag, input logic [1:0] s, input logic [9:0] a,
                        input logic w, input logic r, input logic [31:0] d,
                        input logic [1:0] pd, input logic b);
        chk(tag, 64'({reconfig_select, reconfig_address, reconfig_write, reconfig_read,
                      reconfig_writedata, pll_powerdown, busy}),
                 64'({s, a, w, r, d, pd, b}));
    endtask

    task automatic cyc(input string tag, input logic [1:0] s, input logic [9:0] a,
                       input logic w, input logic r, input logic [31:0] d,
                       input logic [1:0] pd, input logic b);
        look(tag, s, a, w, r, d, pd, b);
        if (reconfig_write && ((reconfig_select & reconfig_waitrequest) == 2'b00)) begin
            wr_done++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 2'b00, 10'h000, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    endtask

    task automatic quiet(input string tag);
        cyc(tag, 2'b00, 10'h000, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
    endtask

    // mode 0 normal, 1 cal_busy never rises, 2 re-request in PWRDN,
    // 3 bus never granted, 4 stop at the WR_CAL cycle.
    task automatic service(input int i, input int mode, input int holds, input string tag);
        logic [1:0] oh;
        oh = 2'b01 << i;
        reconfig_readdata    = '1;
        reconfig_waitrequest = ~oh;
        pll_locked[i]        = 1'b0;
        for (int k = 0; k < holds; k++) begin
            reconfig_waitrequest[i] = 1'b1;
            cyc({tag, "/req_hold"}, oh, 10'h000, 1'b1, 1'b0, 32'h2, 2'b00, 1'b1);
        end
        reconfig_waitrequest[i] = 1'b0;
        cyc({tag, "/req"}, oh, 10'h000, 1'b1, 1'b0, 32'h2, 2'b00, 1'b1);
        reconfig_readdata[i*32 +: 32] = 32'h4;
        if (mode == 3) begin
            for (int k = 0; k < 16; k++) begin
                cyc({tag, "/poll_to"}, oh, 10'h280, 1'b0, 1'b1, 32'h0, 2'b00, 1'b1);
            end
            cyc({tag, "/to_rel"}, oh, 10'h000, 1'b1, 1'b0, 32'h1, 2'b00, 1'b1);
            return;
        end
        cyc({tag, "/poll1"}, oh, 10'h280, 1'b0, 1'b1, 32'h0, 2'b00, 1'b1);
        reconfig_readdata[i*32 +: 32] = 32'h0;
        cyc({tag, "/poll2"}, oh, 10'h280, 1'b0, 1'b1, 32'h0, 2'b00, 1'b1);
        reconfig_readdata[i*32 +: 32] = 32'h10;
        cyc({tag, "/rd_cal"}, oh, 10'h100, 1'b0, 1'b1, 32'h0, 2'b00, 1'b1);
        reconfig_readdata = '1;
        if (mode == 4) return;
        cyc({tag, "/wr_cal"}, oh, 10'h100, 1'b1, 1'b0, 32'h12, 2'b00, 1'b1);
        cyc({tag, "/rel"}, oh, 10'h000, 1'b1, 1'b0, 32'h1, 2'b00, 1'b1);
        if (mode == 1) begin
            for (int k = 0; k < 16; k++) quiet({tag, "/cal_to"});
            return;
        end
        pll_cal_busy[i] = 1'b1;
        quiet({tag, "/cal_hi"});
        pll_cal_busy[i] = 1'b0;
        quiet({tag, "/cal_lo"});
        for (int k = 0; k < 4; k++) begin
            if (mode == 2 && k == 0) recal_req[i] = 1'b1;
            cyc({tag, "/pwrdn"}, 2'b00, 10'h000, 1'b0, 1'b0, 32'h0, oh, 1'b1);
            recal_req = 2'b00;
        end
        quiet({tag, "/lock_wait"});
        pll_locked[i] = 1'b1;
        quiet({tag, "/lock"});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wr_done = 0;
        reset = 1'b1;
        recal_req = 2'b00;
        reconfig_readdata = '1;
        reconfig_waitrequest = 2'b00;
        pll_cal_busy = 2'b00;
        pll_locked = 2'b00;
        repeat (2) @(negedge clk);

        // Reset values.
        look("rst_bus", 2'b00, 10'h000, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
        chk("rst_ready", 64'(ready), 64'(2'b00));
        chk("rst_error", 64'(error), 64'(2'b00));

        // Power-on: both PLLs serviced in order.
        reset = 1'b0;
        idle("por_idle");
        service(0, 0, 0, "por0");
        chk("por0_ready", 64'(ready), 64'(2'b01));
        idle("por_gap");
        service(1, 0, 0, "por1");
        chk("por1_ready", 64'(ready), 64'(2'b11));
        chk("por1_error", 64'(error), 64'(2'b00));
        idle("por_done");

        // Lock loss clears ready without a recalibration.
        pll_locked[0] = 1'b0;
        idle("unlock");
        chk("unlock_ready", 64'(ready), 64'(2'b10));
        pll_locked[0] = 1'b1;
        idle("relock1");
        idle("relock2");
        chk("relock_ready", 64'(ready), 64'(2'b10));

        // Waitrequest held on the bus request write.
        recal_req = 2'b01;
        idle("wr_req");
        recal_req = 2'b00;
        idle("wr_pend");
        wr_base = wr_done;
        service(0, 0, 5, "wr");
        chk("wr_count", 64'(wr_done - wr_base), 64'd3);
        chk("wr_ready", 64'(ready), 64'(2'b11));

        // Simultaneous requests.
        recal_req = 2'b11;
        idle("sim_req");
        recal_req = 2'b00;
        chk("sim_ready_clr", 64'(ready), 64'(2'b00));
        idle("sim_pend");
        service(0, 0, 0, "sim0");
        chk("sim0_ready", 64'(ready), 64'(2'b01));
        idle("sim_gap");
        service(1, 0, 0, "sim1");
        chk("sim1_ready", 64'(ready), 64'(2'b11));

        // Re-request during PWRDN repeats the sequence.
        recal_req = 2'b10;
        idle("rr_req");
        recal_req = 2'b00;
        idle("rr_pend");
        service(1, 2, 0, "rr_a");
        chk("rr_a_ready", 64'(ready), 64'(2'b01));
        idle("rr_gap");
        service(1, 0, 0, "rr_b");
        chk("rr_b_ready", 64'(ready), 64'(2'b11));

        // Calibration never starts on PLL0.
        recal_req = 2'b11;
        idle("cto_req");
        recal_req = 2'b00;
        idle("cto_pend");
        service(0, 1, 0, "cto0");
        chk("cto0_error", 64'(error), 64'(2'b01));
        chk("cto0_ready", 64'(ready), 64'(2'b00));
        idle("cto_gap");
        service(1, 0, 0, "cto1");
        chk("cto1_ready", 64'(ready), 64'(2'b10));
        chk("cto1_error", 64'(error), 64'(2'b01));

        // Bus never granted on PLL1: timeout releases the bus.
        recal_req = 2'b10;
        idle("bto_req");
        recal_req = 2'b00;
        idle("bto_pend");
        service(1, 3, 0, "bto1");
        chk("bto_error", 64'(error), 64'(2'b11));
        chk("bto_ready", 64'(ready), 64'(2'b00));
        idle("bto_done");

        // Reset during WR_CAL of PLL0.
        recal_req = 2'b01;
        idle("ab_req");
        recal_req = 2'b00;
        chk("ab_err_clr", 64'(error), 64'(2'b10));
        idle("ab_pend");
        service(0, 4, 0, "ab0");
        look("ab_wr_cal", 2'b01, 10'h100, 1'b1, 1'b0, 32'h12, 2'b00, 1'b1);
        #2 reset = 1'b1;
        #1;
        look("ab_async", 2'b00, 10'h000, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
        chk("ab_ready", 64'(ready), 64'(2'b00));
        chk("ab_error", 64'(error), 64'(2'b00));
        @(negedge clk);
        reset = 1'b0;
        idle("ab_idle");
        service(0, 0, 0, "ab_re0");
        chk("ab_re0_ready", 64'(ready), 64'(2'b01));
        idle("ab_gap");
        service(1, 0, 0, "ab_re1");
        chk("ab_re1_ready", 64'(ready), 64'(2'b11));
        idle("end_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
